// File: rtl/lcd_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lcd_pkg
//  Description : Shared definitions for the LCD line buffer: panel geometry
//                defaults, RGB565 pixel layout, fill colours and read-FSM
//                state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package lcd_pkg;

    localparam int LCD_WIDTH  = 1024;
    localparam int LCD_HEIGHT = 600;

    typedef struct packed {
        logic [4:0] r;
        logic [5:0] g;
        logic [4:0] b;
    } rgb565_t;

    localparam rgb565_t FILL_BLACK   = rgb565_t'(16'h0000);
    // R=31, G=0, B=31: shown on blank lines so a starved panel is obvious.
    localparam rgb565_t FILL_MAGENTA = rgb565_t'(16'hF81F);

    // Read-FSM state encoding.
    typedef logic [1:0] rd_state_t;
    localparam rd_state_t R_IDLE  = 2'd0;
    localparam rd_state_t R_LINE  = 2'd1;
    localparam rd_state_t R_BLANK = 2'd2;

endpackage
`default_nettype wire

// File: rtl/lcd_line_ram.sv
`default_nettype none
// ============================================================================
//  Module      : lcd_line_ram
//  Description : Simple dual-port line RAM, two banks of 2^ADDR_W x 16 bits,
//                addressed as {bank, pixel}. Synchronous write, synchronous
//                registered read, no reset on the array or read register so
//                the storage maps onto block RAM.
//  Ports       : clk_i    - clock
//                we_i     - write enable
//                waddr_i  - write address {bank, pixel}
//                wdata_i  - write data
//                re_i     - read enable
//                raddr_i  - read address {bank, pixel}
//                rdata_o  - read data, valid the cycle after re_i
//  Revision    : 1.0 - initial release
// ============================================================================
module lcd_line_ram #(
    parameter int ADDR_W = 10
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W:0]   waddr_i,
    input  logic [15:0]       wdata_i,
    input  logic              re_i,
    input  logic [ADDR_W:0]   raddr_i,
    output logic [15:0]       rdata_o
);

    localparam int DEPTH = 2 << ADDR_W;

    logic [15:0] mem_q [DEPTH];
    logic [15:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule
`default_nettype wire

// File: rtl/lcd_line_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : lcd_line_buffer
//  Description : Ping-pong line buffer between a valid/ready RGB565 pixel
//                producer and an RGB panel. One stored line is replayed per
//                active panel line (de_in pulse); panel strobes are delayed
//                one cycle to stay aligned with the pixel data.
//  Config      : LCD_LB_UNDERFLOW_MARK_EN - when defined, lines displayed
//                without a full bank are painted magenta instead of black.
//  Ports       : PixelClk, nRST (sync, active-low)
//                in_valid/in_ready/in_data/in_sol - pixel input stream
//                de_in/hs_in/vs_in - timing-generator strobes
//                LCD_DE/LCD_HSYNC/LCD_VSYNC/LCD_R/LCD_G/LCD_B - panel outputs
//                underflow/resync - sticky status, cleared by clr_flags
//  Revision    : 1.0 - initial release
// ============================================================================
module lcd_line_buffer
    import lcd_pkg::*;
#(
    parameter int WIDTH  = LCD_WIDTH,
    parameter int ADDR_W = 10
) (
    input  logic        PixelClk,
    input  logic        nRST,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_data,
    input  logic        in_sol,
    input  logic        de_in,
    input  logic        hs_in,
    input  logic        vs_in,
    output logic        LCD_DE,
    output logic        LCD_HSYNC,
    output logic        LCD_VSYNC,
    output logic [4:0]  LCD_R,
    output logic [5:0]  LCD_G,
    output logic [4:0]  LCD_B,
    output logic        underflow,
    output logic        resync,
    input  logic        clr_flags
);

`ifdef LCD_LB_UNDERFLOW_MARK_EN
    localparam rgb565_t BLANK_FILL = FILL_MAGENTA;
`else
    localparam rgb565_t BLANK_FILL = FILL_BLACK;
`endif

    localparam logic [ADDR_W-1:0] WCNT_LAST = ADDR_W'(WIDTH - 1);
    localparam logic [ADDR_W:0]   RCNT_END  = (ADDR_W + 1)'(WIDTH);

    // State
    logic [1:0]        full_q, full_d;
    logic              wb_q, wb_d;
    logic              rb_q, rb_d;
    logic [ADDR_W-1:0] wcnt_q, wcnt_d;
    logic [ADDR_W:0]   rcnt_q, rcnt_d;
    rd_state_t         state_q, state_d;
    logic              underflow_q, underflow_d;
    logic              resync_q, resync_d;
    logic              pix_sel_q, pix_sel_d;   // 1: RAM data, 0: fill colour
    rgb565_t           fill_q, fill_d;
    logic              de_q, hs_q, vs_q;

    // Combinational
    logic              wr_fire, wr_resync, wr_last;
    logic [ADDR_W-1:0] wr_idx;
    logic              de_rise, de_fall;
    logic              rd_en;
    logic              uf_set;
    logic [15:0]       ram_rdata;
    rgb565_t           pix_out;

    assign in_ready  = nRST & ~full_q[wb_q];
    assign wr_fire   = in_valid & in_ready;
    // A start-of-line marker mid-line drops the partial line and restarts at 0.
    assign wr_resync = wr_fire & in_sol & (wcnt_q != '0);
    assign wr_last   = wr_fire & ~wr_resync & (wcnt_q == WCNT_LAST);
    assign wr_idx    = wr_resync ? {ADDR_W{1'b0}} : wcnt_q;

    // de_q doubles as the delayed LCD_DE, so the first de_in cycle is both
    // the rise detection and the read of pixel 0.
    assign de_rise = de_in & ~de_q;
    assign de_fall = ~de_in & de_q;

    always_comb begin
        full_d    = full_q;
        wb_d      = wb_q;
        rb_d      = rb_q;
        wcnt_d    = wcnt_q;
        rcnt_d    = rcnt_q;
        state_d   = state_q;
        pix_sel_d = 1'b0;
        fill_d    = FILL_BLACK;
        rd_en     = 1'b0;
        uf_set    = 1'b0;

        // Read side
        case (state_q)
            R_IDLE: begin
                if (de_rise) begin
                    if (full_q[rb_q]) begin
                        state_d   = R_LINE;
                        rd_en     = 1'b1;
                        pix_sel_d = 1'b1;
                        rcnt_d    = rcnt_q + (ADDR_W + 1)'(1);
                    end else begin
                        state_d = R_BLANK;
                        uf_set  = 1'b1;
                        fill_d  = BLANK_FILL;
                    end
                end
            end
            R_LINE: begin
                if (de_fall) begin
                    state_d      = R_IDLE;
                    full_d[rb_q] = 1'b0;
                    rb_d         = ~rb_q;
                    rcnt_d       = '0;
                end else if (de_in && (rcnt_q < RCNT_END)) begin
                    rd_en     = 1'b1;
                    pix_sel_d = 1'b1;
                    rcnt_d    = rcnt_q + (ADDR_W + 1)'(1);
                end
            end
            R_BLANK: begin
                if (de_fall) begin
                    state_d = R_IDLE;
                end else if (de_in) begin
                    fill_d = BLANK_FILL;
                end
            end
            default: begin
                state_d = R_IDLE;
            end
        endcase

        // Write side; never touches the bank the reader is releasing
        // because a full bank stalls the writer on it.
        if (wr_resync) begin
            wcnt_d = ADDR_W'(1);
        end else if (wr_last) begin
            wcnt_d       = '0;
            full_d[wb_q] = 1'b1;
            wb_d         = ~wb_q;
        end else if (wr_fire) begin
            wcnt_d = wcnt_q + ADDR_W'(1);
        end

        // A same-cycle set wins over clr_flags.
        underflow_d = uf_set    | (underflow_q & ~clr_flags);
        resync_d    = wr_resync | (resync_q    & ~clr_flags);
    end

    always_ff @(posedge PixelClk) begin
        if (!nRST) begin
            full_q      <= '0;
            wb_q        <= 1'b0;
            rb_q        <= 1'b0;
            wcnt_q      <= '0;
            rcnt_q      <= '0;
            state_q     <= R_IDLE;
            underflow_q <= 1'b0;
            resync_q    <= 1'b0;
            pix_sel_q   <= 1'b0;
            fill_q      <= FILL_BLACK;
            de_q        <= 1'b0;
            hs_q        <= 1'b1;
            vs_q        <= 1'b1;
        end else begin
            full_q      <= full_d;
            wb_q        <= wb_d;
            rb_q        <= rb_d;
            wcnt_q      <= wcnt_d;
            rcnt_q      <= rcnt_d;
            state_q     <= state_d;
            underflow_q <= underflow_d;
            resync_q    <= resync_d;
            pix_sel_q   <= pix_sel_d;
            fill_q      <= fill_d;
            de_q        <= de_in;
            hs_q        <= hs_in;
            vs_q        <= vs_in;
        end
    end

    lcd_line_ram #(
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk_i   (PixelClk),
        .we_i    (wr_fire),
        .waddr_i ({wb_q, wr_idx}),
        .wdata_i (in_data),
        .re_i    (rd_en),
        .raddr_i ({rb_q, rcnt_q[ADDR_W-1:0]}),
        .rdata_o (ram_rdata)
    );

    // Both mux inputs are registers, so the pixel lines up with LCD_DE.
    assign pix_out   = pix_sel_q ? rgb565_t'(ram_rdata) : fill_q;
    assign LCD_R     = pix_out.r;
    assign LCD_G     = pix_out.g;
    assign LCD_B     = pix_out.b;
    assign LCD_DE    = de_q;
    assign LCD_HSYNC = hs_q;
    assign LCD_VSYNC = vs_q;
    assign underflow = underflow_q;
    assign resync    = resync_q;

endmodule
`default_nettype wire
